// File: rtl/float_div.sv
// Multi-cycle IEEE-754 single-precision divider (out = ain / bin) with valid/ready
// handshakes, 26-step restoring mantissa division, RNE rounding and flush-to-zero.
module float_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ain,
    input  logic [31:0] bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        dz
);

    localparam int unsigned ITERS = 26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ITER,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       a_q, b_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [23:0]       mb_q;
    logic [24:0]       rem_q;
    logic [25:0]       quo_q;
    logic [4:0]        cnt_q;
    logic              spec_q, spec_dz_q;
    logic [31:0]       spec_val_q;
    logic [31:0]       out_q;
    logic              dz_q;

    // Operand classification
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign_up;
    logic              spec_hit, spec_dz;
    logic [31:0]       spec_val;
    logic signed [9:0] exp_up;

    assign a_zero  = (a_q[30:23] == 8'h00);
    assign b_zero  = (b_q[30:23] == 8'h00);
    assign a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    assign sign_up = a_q[31] ^ b_q[31];
    assign exp_up  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;

    always_comb begin
        spec_hit = 1'b1;
        spec_dz  = 1'b0;
        spec_val = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_val = 32'h7FC0_0000;
        end else if (a_inf) begin
            spec_val = {sign_up, 8'hFF, 23'd0};
        end else if (b_inf) begin
            spec_val = {sign_up, 31'd0};
        end else if (b_zero) begin
            spec_val = {sign_up, 8'hFF, 23'd0};
            spec_dz  = 1'b1;
        end else if (a_zero) begin
            spec_val = {sign_up, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Restoring division step
    logic        ge;
    logic [24:0] diff;

    assign ge   = (rem_q >= {1'b0, mb_q});
    assign diff = ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    // Normalise and round; the rounding increment ripples from the fraction into the exponent
    logic [22:0]       frac_n;
    logic signed [9:0] exp_n, exp_r;
    logic              guard, sticky_n, inc;
    logic [32:0]       rsum;
    logic [31:0]       packed_res;

    always_comb begin
        if (quo_q[25]) begin
            frac_n   = quo_q[24:2];
            guard    = quo_q[1];
            sticky_n = (|rem_q) | quo_q[0];
            exp_n    = exp_q;
        end else begin
            frac_n   = quo_q[23:1];
            guard    = quo_q[0];
            sticky_n = |rem_q;
            exp_n    = exp_q - 10'sd1;
        end
        inc   = guard & (sticky_n | frac_n[0]);
        rsum  = {exp_n, frac_n} + {32'd0, inc};
        exp_r = $signed(rsum[32:23]);
        if (exp_r >= 10'sd255) begin
            packed_res = {sign_q, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            packed_res = {sign_q, 31'd0};
        end else begin
            packed_res = {sign_q, exp_r[7:0], rsum[22:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_UNPACK;
            S_UNPACK: state_d = S_ITER;
            S_ITER:   if (cnt_q == 5'(ITERS - 1)) state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mb_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_dz_q  <= 1'b0;
            spec_val_q <= '0;
            out_q      <= '0;
            dz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q <= ain;
                        b_q <= bin;
                    end
                end
                S_UNPACK: begin
                    sign_q     <= sign_up;
                    exp_q      <= exp_up;
                    rem_q      <= {2'b01, a_q[22:0]};
                    mb_q       <= {1'b1, b_q[22:0]};
                    quo_q      <= '0;
                    cnt_q      <= '0;
                    spec_q     <= spec_hit;
                    spec_dz_q  <= spec_dz;
                    spec_val_q <= spec_val;
                end
                S_ITER: begin
                    rem_q <= diff << 1;
                    quo_q <= {quo_q[24:0], ge};
                    cnt_q <= cnt_q + 5'd1;
                end
                S_ROUND: begin
                    out_q <= spec_q ? spec_val_q : packed_res;
                    dz_q  <= spec_q & spec_dz_q;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign dz        = dz_q;

endmodule
